regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_wr_arbiter_if.sv | 36 +++
 rtl/regfile_wr_arbiter_rr_arb2.sv | 33 +++
 rtl/regfile_wr_arbiter.sv | 112 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the write-request record for the register-file write arbiter.
package regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // One buffered writeback: destination register and data.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wr_req_t;

    // One-hot decode of a register index.
    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
        logic [NREG-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request handshakes, the regFile write port and the pending-write mask.
interface regfile_wr_arbiter_if;
    import regfile_pkg::*;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [REG_ADDR_W-1:0] req0_rd;
    logic [XLEN-1:0]       req0_data;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [REG_ADDR_W-1:0] req1_rd;
    logic [XLEN-1:0]       req1_data;

    logic                  wen;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       dIn;
    logic [NREG-1:0]       pend_mask;

    // Requesters / regFile / hazard logic side.
    modport master (
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        input  req0_ready, req1_ready,
        input  wen, rd, dIn, pend_mask
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        output req0_ready, req1_ready,
        output wen, rd, dIn, pend_mask
    );

endinterface

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; ptr names the requester favoured on a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       next_ptr
);

    // Grant decode; the pointer always moves to the index that was not granted.
    always_comb begin
        grant    = 2'b00;
        next_ptr = ptr;
        case (req)
            2'b11: begin
                grant[ptr] = 1'b1;
                next_ptr   = ~ptr;
            end
            2'b01: begin
                grant    = 2'b01;
                next_ptr = 1'b1;
            end
            2'b10: begin
                grant    = 2'b10;
                next_ptr = 1'b0;
            end
            default: begin
                grant    = 2'b00;
                next_ptr = ptr;
            end
        endcase
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the regFile write port between ALU (req0) and LSU (req1) writebacks.
module regfile_wr_arbiter
    import regfile_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    regfile_wr_arbiter_if.slave bus
);

    logic [1:0]            full_q, full_d;
    wr_req_t               buf_q [2];
    wr_req_t               buf_d [2];
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       din_q, din_d;

    logic [1:0] grant;
    logic [1:0] valid;
    logic [1:0] ready;
    logic [1:0] accept;
    wr_req_t    req_in [2];

    assign valid     = {bus.req1_valid, bus.req0_valid};
    assign req_in[0] = '{rd: bus.req0_rd, data: bus.req0_data};
    assign req_in[1] = '{rd: bus.req1_rd, data: bus.req1_data};

    // Grants depend only on registered state, so ready never depends on valid.
    rr_arb2 u_arb (
        .req      (full_q),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .next_ptr (rr_ptr_d)
    );

    assign ready          = ~full_q | grant;
    assign accept         = valid & ready;
    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];

    // Holding buffers: drain on grant, refill on accept; writes to x0 are dropped.
    always_comb begin
        full_d = full_q;
        buf_d  = buf_q;
        for (int i = 0; i < 2; i++) begin
            if (grant[i]) begin
                full_d[i] = 1'b0;
            end
            if (accept[i] && (req_in[i].rd != '0)) begin
                full_d[i] = 1'b1;
                buf_d[i]  = req_in[i];
            end
        end
    end

    // Write stage: load the granted buffer; address/data hold when idle.
    always_comb begin
        wen_d = 1'b0;
        rd_d  = rd_q;
        din_d = din_q;
        if (grant[0]) begin
            wen_d = 1'b1;
            rd_d  = buf_q[0].rd;
            din_d = buf_q[0].data;
        end else if (grant[1]) begin
            wen_d = 1'b1;
            rd_d  = buf_q[1].rd;
            din_d = buf_q[1].data;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rr_ptr_q <= 1'b0;
            wen_q    <= 1'b0;
            rd_q     <= '0;
            din_q    <= '0;
        end else begin
            full_q   <= full_d;
            buf_q    <= buf_d;
            rr_ptr_q <= rr_ptr_d;
            wen_q    <= wen_d;
            rd_q     <= rd_d;
            din_q    <= din_d;
        end
    end

    // Pending destinations: both buffers plus the write stage; x0 is never pending.
    always_comb begin
        bus.pend_mask = '0;
        if (full_q[0]) begin
            bus.pend_mask = bus.pend_mask | reg_onehot(buf_q[0].rd);
        end
        if (full_q[1]) begin
            bus.pend_mask = bus.pend_mask | reg_onehot(buf_q[1].rd);
        end
        if (wen_q) begin
            bus.pend_mask = bus.pend_mask | reg_onehot(rd_q);
        end
        bus.pend_mask[0] = 1'b0;
    end

    // A staged write is squashed on a reset edge so regFile never sees it.
    assign bus.wen = wen_q & ~rst;
    assign bus.rd  = rd_q;
    assign bus.dIn = din_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a regFile model and a write log.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if ifc ();

    regfile_wr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    int checks   = 0;
    int failures = 0;

    // regFile model and write log.
    logic [XLEN-1:0]       regs    [NREG] = '{default: '0};
    logic [REG_ADDR_W-1:0] log_rd  [128];
    logic [XLEN-1:0]       log_d   [128];
    int                    log_cyc [128];
    int                    log_n = 0;
    int                    cyc   = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifc.wen) begin
            regs[ifc.rd] <= ifc.dIn;
            if (log_n < 128) begin
                log_rd[log_n]  <= ifc.rd;
                log_d[log_n]   <= ifc.dIn;
                log_cyc[log_n] <= cyc;
            end
            log_n <= log_n + 1;
        end
    end

    typedef struct {
        logic                  v0;
        logic [REG_ADDR_W-1:0] rd0;
        logic [XLEN-1:0]       d0;
        logic                  v1;
        logic [REG_ADDR_W-1:0] rd1;
        logic [XLEN-1:0]       d1;
        logic                  e_wen;
        logic [REG_ADDR_W-1:0] e_rd;
        logic [XLEN-1:0]       e_din;
        logic                  e_r0;
        logic                  e_r1;
        logic [NREG-1:0]       e_pend;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [31:0] d1);
        ifc.req0_valid = v0;
        ifc.req0_rd    = rd0;
        ifc.req0_data  = d0;
        ifc.req1_valid = v1;
        ifc.req1_rd    = rd1;
        ifc.req1_data  = d1;
    endtask

    initial begin
        int base;
        int i0;
        int i1;
        logic a0;
        logic a1;
        logic [4:0]  exp_rd [8];
        logic [31:0] exp_d  [8];

        // ---- reset with req0_valid held ----
        rst = 1'b1;
        drive(1'b1, 5'd7, 32'h0000_0077, 1'b0, 5'd0, 32'h0);
        step();
        step();
        chk("rst_wen", 32'(ifc.wen), 32'd0);
        chk("rst_pend", ifc.pend_mask, 32'd0);
        chk("rst_ready0", 32'(ifc.req0_ready), 32'd1);
        chk("rst_ready1", 32'(ifc.req1_ready), 32'd1);
        chk("rst_no_write", 32'(log_n), 32'd0);
        rst = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk("post_rst_wen", 32'(ifc.wen), 32'd0);
        chk("post_rst_pend", ifc.pend_mask, 32'd0);
        chk("post_rst_log", 32'(log_n), 32'd0);

        // ---- per-cycle vector table (starts idle, rr_ptr = 0) ----
        vecs[0]  = '{1'b1, 5'd5, 32'hFFFF_FF05, 1'b0, 5'd0,  32'h0,
                     1'b0, 5'd0,  32'h0,         1'b1, 1'b1, 32'h0000_0020};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,
                     1'b1, 5'd5,  32'hFFFF_FF05, 1'b1, 1'b1, 32'h0000_0020};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,
                     1'b0, 5'd5,  32'hFFFF_FF05, 1'b1, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0,  32'h0000_0123,
                     1'b0, 5'd5,  32'hFFFF_FF05, 1'b1, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,
                     1'b0, 5'd5,  32'hFFFF_FF05, 1'b1, 1'b1, 32'h0};
        vecs[5]  = '{1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd17, 32'h0000_00B1,
                     1'b0, 5'd5,  32'hFFFF_FF05, 1'b0, 1'b1, 32'h0002_0002};
        vecs[6]  = '{1'b1, 5'd1, 32'h0000_00A1, 1'b0, 5'd0,  32'h0,
                     1'b1, 5'd17, 32'h0000_00B1, 1'b1, 1'b1, 32'h0002_0002};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,
                     1'b1, 5'd1,  32'h0000_00A1, 1'b1, 1'b1, 32'h0000_0002};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,
                     1'b0, 5'd1,  32'h0000_00A1, 1'b1, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 5'd3, 32'h0000_00C3, 1'b0, 5'd0,  32'h0,
                     1'b0, 5'd1,  32'h0000_00A1, 1'b1, 1'b1, 32'h0000_0008};
        vecs[10] = '{1'b1, 5'd4, 32'h0000_00C4, 1'b0, 5'd0,  32'h0,
                     1'b1, 5'd3,  32'h0000_00C3, 1'b1, 1'b1, 32'h0000_0018};
        vecs[11] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,
                     1'b1, 5'd4,  32'h0000_00C4, 1'b1, 1'b1, 32'h0000_0010};
        vecs[12] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,
                     1'b0, 5'd4,  32'h0000_00C4, 1'b1, 1'b1, 32'h0};

        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].v0, vecs[k].rd0, vecs[k].d0, vecs[k].v1, vecs[k].rd1, vecs[k].d1);
            step();
            chk($sformatf("vec%0d_wen", k), 32'(ifc.wen), 32'(vecs[k].e_wen));
            chk($sformatf("vec%0d_rd", k), 32'(ifc.rd), 32'(vecs[k].e_rd));
            chk($sformatf("vec%0d_din", k), ifc.dIn, vecs[k].e_din);
            chk($sformatf("vec%0d_ready0", k), 32'(ifc.req0_ready), 32'(vecs[k].e_r0));
            chk($sformatf("vec%0d_ready1", k), 32'(ifc.req1_ready), 32'(vecs[k].e_r1));
            chk($sformatf("vec%0d_pend", k), ifc.pend_mask, vecs[k].e_pend);
        end
        chk("table_write_count", 32'(log_n), 32'd5);

        // ---- both requesters streaming; reset first so req0 wins the first tie ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        base = log_n;
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 40 && (i0 < 4 || i1 < 4); c++) begin
            drive(i0 < 4, 5'(1 + i0), 32'hA000_0000 | 32'(1 + i0),
                  i1 < 4, 5'(17 + i1), 32'hB000_0000 | 32'(17 + i1));
            a0 = ifc.req0_valid & ifc.req0_ready;
            a1 = ifc.req1_valid & ifc.req1_ready;
            step();
            if (a0) i0++;
            if (a1) i1++;
        end
        chk("stream_all_accepted", 32'(i0 + i1), 32'd8);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int c = 0; c < 4; c++) step();
        exp_rd = '{5'd1, 5'd17, 5'd2, 5'd18, 5'd3, 5'd19, 5'd4, 5'd20};
        for (int k = 0; k < 8; k++) begin
            exp_d[k] = ((k % 2) == 0 ? 32'hA000_0000 : 32'hB000_0000) | 32'(exp_rd[k]);
        end
        chk("stream_count", 32'(log_n - base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (base + k < 128) begin
                chk($sformatf("stream%0d_rd", k), 32'(log_rd[base + k]), 32'(exp_rd[k]));
                chk($sformatf("stream%0d_data", k), log_d[base + k], exp_d[k]);
                chk($sformatf("stream%0d_cycle", k), 32'(log_cyc[base + k] - log_cyc[base]),
                    32'(k));
            end
        end

        // ---- 32 back-to-back req0 writes, x0 included ----
        base = log_n;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'hFFFF_FF00 + 32'(i), 1'b0, 5'd0, 32'h0);
            chk($sformatf("burst%0d_ready", i), 32'(ifc.req0_ready), 32'd1);
            step();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int c = 0; c < 4; c++) step();
        chk("burst_count", 32'(log_n - base), 32'd31);
        chk("burst_span", 32'(log_cyc[log_n - 1] - log_cyc[base]), 32'd30);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("regfile_x%0d", i), regs[i], (i == 0) ? 32'h0 : 32'hFFFF_FF00 + 32'(i));
        end

        // ---- reset while both buffers are full and a write is staged ----
        drive(1'b1, 5'd9, 32'hD000_0009, 1'b1, 5'd10, 32'hD000_000A);
        step();
        chk("midrst_both_full_pend", ifc.pend_mask, 32'h0000_0600);
        // rr_ptr = 1 after the burst, so req1 wins; req0 holds its request.
        drive(1'b1, 5'd9, 32'hD000_0009, 1'b1, 5'd12, 32'hD000_000C);
        step();
        chk("midrst_wen", 32'(ifc.wen), 32'd1);
        chk("midrst_rd", 32'(ifc.rd), 32'd10);
        chk("midrst_pend", ifc.pend_mask, 32'h0000_1600);
        base = log_n;
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        chk("midrst_after_wen", 32'(ifc.wen), 32'd0);
        chk("midrst_after_pend", ifc.pend_mask, 32'd0);
        chk("midrst_after_ready0", 32'(ifc.req0_ready), 32'd1);
        chk("midrst_after_ready1", 32'(ifc.req1_ready), 32'd1);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("midrst_no_writes", 32'(log_n - base), 32'd0);
        chk("midrst_x9", regs[9], 32'hFFFF_FF09);
        chk("midrst_x10", regs[10], 32'hFFFF_FF0A);
        chk("midrst_x12", regs[12], 32'hFFFF_FF0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
